// File: rtl/fetch_pc_unit.sv
// Fetch program counter with trap/redirect/return-prediction arbitration.
// Drives the fetch address through a valid/ready handshake and tags each fetch with an epoch bit.
module fetch_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h8000_0100,
    parameter int              STEP         = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_n,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    output logic            fetch_epoch,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam int              PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int              CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [XLEN-1:0]  STEP_INC  = XLEN'(STEP);

    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FROZEN} state_t;

    state_t           state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic             epoch_reg, epoch_next;
    logic             misaligned_reg, misaligned_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] top_reg, top_next;
    logic             ras_empty_reg, ras_full_reg;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [RAS_DEPTH-1:0] ras_wen;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;

    logic             active, fire, do_push, do_pop;
    logic [XLEN-1:0]  pc_plus, ras_top;
    logic [PTR_W-1:0] top_inc, top_dec;

    assign active  = (state_reg == ST_RUN) && !enable_n;
    assign fire    = active && fetch_ready;
    assign pc_plus = pc_reg + STEP_INC;
    assign ras_top = ras_mem[top_reg];
    assign top_inc = (top_reg == LAST_IDX) ? '0 : top_reg + PTR_W'(1);
    assign top_dec = (top_reg == '0) ? LAST_IDX : top_reg - PTR_W'(1);

    always_comb begin
        state_next = state_reg;
        if (enable_n) begin
            if (state_reg == ST_RUN) begin
                state_next = ST_FROZEN;
            end
        end else begin
            state_next = ST_RUN;
        end
    end

    // Trap beats redirect beats return prediction beats sequential advance.
    always_comb begin
        pc_next         = pc_reg;
        epoch_next      = epoch_reg;
        misaligned_next = 1'b0;
        do_push         = 1'b0;
        do_pop          = 1'b0;
        if (active) begin
            if (trap_valid) begin
                pc_next    = TRAP_VECTOR;
                epoch_next = ~epoch_reg;
            end else if (redirect_valid) begin
                epoch_next = ~epoch_reg;
                if (redirect_addr[ALIGN_BITS-1:0] != '0) begin
                    pc_next         = TRAP_VECTOR;
                    misaligned_next = 1'b1;
                end else begin
                    pc_next = redirect_addr;
                end
            end else if (fire) begin
                do_push = ras_push;
                do_pop  = ras_pop && (count_reg != '0);
                pc_next = do_pop ? ras_top : pc_plus;
            end
        end
    end

    // Circular stack: a push when full lands on the oldest slot, which follows the top.
    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        ras_we     = 1'b0;
        ras_waddr  = top_reg;
        if (do_push && do_pop) begin
            ras_we    = 1'b1;
            ras_waddr = top_reg;
        end else if (do_push) begin
            ras_we    = 1'b1;
            ras_waddr = top_inc;
            top_next  = top_inc;
            if (count_reg != DEPTH_CNT) begin
                count_next = count_reg + CNT_W'(1);
            end
        end else if (do_pop) begin
            top_next   = top_dec;
            count_next = count_reg - CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_wen
            assign ras_wen[gi] = ras_we && (ras_waddr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (ras_wen[i]) begin
                ras_mem[i] <= pc_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RESET;
            pc_reg         <= RESET_VECTOR;
            epoch_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
            count_reg      <= '0;
            top_reg        <= '0;
            ras_empty_reg  <= 1'b1;
            ras_full_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            epoch_reg      <= epoch_next;
            misaligned_reg <= misaligned_next;
            count_reg      <= count_next;
            top_reg        <= top_next;
            ras_empty_reg  <= (count_next == '0);
            ras_full_reg   <= (count_next == DEPTH_CNT);
        end
    end

    assign fetch_valid = active;
    assign fetch_addr  = pc_reg;
    assign fetch_epoch = epoch_reg;
    assign misaligned  = misaligned_reg;
    assign ras_empty   = ras_empty_reg;
    assign ras_full    = ras_full_reg;

endmodule
